multi_axis_angle_controller: RTL and testbench

//  Parametrised N-axis successor to the fixed 4-axis angle stage. Maps receiver targets to signed rate set-points.
//  Per channel: angle mode (subtract IMU angle) or rate mode (pass-through), per-channel gain, shift and limit.
//  One shared multiply/scale/saturate datapath, time-multiplexed across channels.

---
 rtl/multi_axis_angle_controller_pkg.sv | 36 +++
 rtl/multi_axis_angle_controller_scale_saturate.sv | 45 ++++
 rtl/multi_axis_angle_controller.sv | 189 ++++++++++++++++++
 tb/tb_multi_axis_angle_controller.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_axis_angle_controller_pkg.sv
// Shared widths, constants, FSM encoding and saturation helper for the
// multi-axis angle controller.
package multi_axis_angle_controller_pkg;

  localparam int RATE_BIT_WIDTH    = 16;
  localparam int REC_VAL_BIT_WIDTH = 8;
  localparam int OPS_BIT_WIDTH     = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic signed [RATE_BIT_WIDTH-1:0] RATE_ZERO = '0;
  localparam logic signed [OPS_BIT_WIDTH-1:0]  OPS_ZERO  = '0;

  localparam logic signed [OPS_BIT_WIDTH-1:0] RATE_POS_MAX = 32'sd32767;
  localparam logic signed [OPS_BIT_WIDTH-1:0] RATE_NEG_MAX = -32'sd32768;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_MAP      = 3'd2,
    ST_SCALE    = 3'd3,
    ST_LIMIT    = 3'd4,
    ST_COMPLETE = 3'd5
  } ctrl_state_t;

  // Clamp a wide intermediate into the signed rate range.
  function automatic logic signed [RATE_BIT_WIDTH-1:0] sat_to_rate(
    input logic signed [OPS_BIT_WIDTH-1:0] v
  );
    if (v > RATE_POS_MAX) return 16'sh7fff;
    if (v < RATE_NEG_MAX) return 16'sh8000;
    return v[RATE_BIT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/multi_axis_angle_controller_scale_saturate.sv
// Shared combinational multiply / arithmetic-shift / clamp stage used by
// every channel in turn.
module scale_saturate
  import multi_axis_angle_controller_pkg::*;
#(
  parameter int RATE_W = RATE_BIT_WIDTH
) (
  input  logic signed [OPS_BIT_WIDTH-1:0] m,
  input  logic signed [7:0]               k_mult,
  input  logic [3:0]                      k_shift,
  input  logic [RATE_W-1:0]               limit,
  input  logic                            unipolar,
  output logic signed [RATE_W-1:0]        rate,
  output logic                            sat
);

  localparam int PW = OPS_BIT_WIDTH + 8;

  logic signed [PW-1:0] m_ext;
  logic signed [PW-1:0] k_ext;
  logic signed [PW-1:0] product;
  logic signed [PW-1:0] scaled;
  logic signed [PW-1:0] hi;
  logic signed [PW-1:0] lo;

  // Product is kept 8 bits wider than the operands so the shift never sees a wrap.
  always_comb begin
    m_ext   = {{8{m[OPS_BIT_WIDTH-1]}}, m};
    k_ext   = {{OPS_BIT_WIDTH{k_mult[7]}}, k_mult};
    product = m_ext * k_ext;
    scaled  = product >>> k_shift;
    hi      = {{(PW-RATE_W){1'b0}}, limit};
    lo      = unipolar ? '0 : -hi;
    rate    = scaled[RATE_W-1:0];
    sat     = FALSE;
    if (scaled > hi) begin
      rate = hi[RATE_W-1:0];
      sat  = TRUE;
    end else if (scaled < lo) begin
      rate = lo[RATE_W-1:0];
      sat  = TRUE;
    end
  end

endmodule

// File: rtl/multi_axis_angle_controller.sv
// N-axis angle/rate set-point stage: one time-multiplexed MAP/SCALE/LIMIT
// datapath per channel, double-buffered outputs for the rate controller.
module multi_axis_angle_controller
  import multi_axis_angle_controller_pkg::*;
#(
  parameter int                       N_AXES        = 4,
  parameter int                       REC_W         = REC_VAL_BIT_WIDTH,
  parameter int                       RATE_W        = RATE_BIT_WIDTH,
  parameter int                       MAP_SHIFT     = 2,
  parameter int                       MAP_OFFSET    = 500,
  parameter int                       UNI_SHIFT     = 4,
  parameter logic [N_AXES*8-1:0]      K_MULT_VEC    = {8'd36, 8'd32, 8'd48, 8'd1},
  parameter logic [N_AXES*4-1:0]      K_SHIFT_VEC   = {4'd4, 4'd4, 4'd4, 4'd0},
  parameter logic [N_AXES*RATE_W-1:0] LIMIT_VEC     = {16'd1600, 16'd1600, 16'd1600, 16'd4000},
  parameter logic [N_AXES-1:0]        UNIPOLAR_MASK = 4'b0001,
  parameter logic [N_AXES-1:0]        INVERT_MASK   = 4'b1000
) (
  input  logic                       us_clk,
  input  logic                       reset,
  input  logic                       start_signal,
  input  logic [N_AXES-1:0]          angle_mode,
  input  logic [N_AXES*REC_W-1:0]    target_in,
  input  logic [N_AXES*RATE_W-1:0]   actual_in,
  output logic [N_AXES*RATE_W-1:0]   rate_out,
  output logic [N_AXES*RATE_W-1:0]   angle_error,
  output logic [N_AXES-1:0]          sat_flags,
  output logic                       active_signal,
  output logic                       complete_signal
);

  localparam int CH_W = (N_AXES > 1) ? $clog2(N_AXES) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_AXES - 1);

  ctrl_state_t state;
  logic [CH_W-1:0] ch;
  logic start_latch;

  logic [N_AXES*REC_W-1:0]  tgt_q;
  logic [N_AXES*RATE_W-1:0] act_q;
  logic [N_AXES-1:0]        mode_q;

  logic signed [OPS_BIT_WIDTH-1:0] m_q;
  logic signed [RATE_W-1:0]        rate_q;
  logic signed [RATE_W-1:0]        err_q;
  logic                            sat_q;

  logic [N_AXES*RATE_W-1:0] rate_sh;
  logic [N_AXES*RATE_W-1:0] err_sh;
  logic [N_AXES-1:0]        sat_sh;
  logic [N_AXES*RATE_W-1:0] rate_nx;
  logic [N_AXES*RATE_W-1:0] err_nx;
  logic [N_AXES-1:0]        sat_nx;

  logic [REC_W-1:0]                tgt_ch;
  logic signed [RATE_W-1:0]        act_ch;
  logic signed [OPS_BIT_WIDTH-1:0] tgt_ext;
  logic signed [OPS_BIT_WIDTH-1:0] act_ext;
  logic signed [OPS_BIT_WIDTH-1:0] m_next;
  logic signed [7:0]               k_ch;
  logic [3:0]                      ks_ch;
  logic [RATE_W-1:0]               lim_ch;

  logic signed [RATE_W-1:0] ss_rate;
  logic                     ss_sat;

  // Channel-select muxes and the MAP arithmetic for the current channel.
  always_comb begin
    tgt_ch  = tgt_q[ch*REC_W +: REC_W];
    act_ch  = act_q[ch*RATE_W +: RATE_W];
    k_ch    = K_MULT_VEC[ch*8 +: 8];
    ks_ch   = K_SHIFT_VEC[ch*4 +: 4];
    lim_ch  = LIMIT_VEC[ch*RATE_W +: RATE_W];
    tgt_ext = {{(OPS_BIT_WIDTH-REC_W){1'b0}}, tgt_ch};
    act_ext = {{(OPS_BIT_WIDTH-RATE_W){act_ch[RATE_W-1]}}, act_ch};
    if (UNIPOLAR_MASK[ch]) begin
      m_next = tgt_ext <<< UNI_SHIFT;
    end else begin
      m_next = (tgt_ext <<< MAP_SHIFT) - MAP_OFFSET;
      if (mode_q[ch]) begin
        m_next = INVERT_MASK[ch] ? (m_next + act_ext) : (m_next - act_ext);
      end
    end
  end

  // Shadow set with the channel finishing this cycle merged in, so the
  // last channel reaches the outputs on the same edge as the others.
  always_comb begin
    rate_nx = rate_sh;
    err_nx  = err_sh;
    sat_nx  = sat_sh;
    rate_nx[ch*RATE_W +: RATE_W] = rate_q;
    err_nx[ch*RATE_W +: RATE_W]  = err_q;
    sat_nx[ch]                   = sat_q;
  end

  scale_saturate #(
    .RATE_W(RATE_W)
  ) u_scale_saturate (
    .m        (m_q),
    .k_mult   (k_ch),
    .k_shift  (ks_ch),
    .limit    (lim_ch),
    .unipolar (UNIPOLAR_MASK[ch]),
    .rate     (ss_rate),
    .sat      (ss_sat)
  );

  // Sequencer: one pending start is remembered while busy, outputs only
  // change on the single edge that enters COMPLETE.
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      ch              <= '0;
      start_latch     <= FALSE;
      tgt_q           <= '0;
      act_q           <= '0;
      mode_q          <= '0;
      m_q             <= OPS_ZERO;
      rate_q          <= RATE_ZERO;
      err_q           <= RATE_ZERO;
      sat_q           <= FALSE;
      rate_sh         <= '0;
      err_sh          <= '0;
      sat_sh          <= '0;
      rate_out        <= '0;
      angle_error     <= '0;
      sat_flags       <= '0;
      active_signal   <= FALSE;
      complete_signal <= FALSE;
    end else begin
      if (start_signal && (state != ST_IDLE)) begin
        start_latch <= TRUE;
      end
      case (state)
        ST_IDLE: begin
          complete_signal <= FALSE;
          if (start_signal || start_latch) begin
            start_latch   <= FALSE;
            active_signal <= TRUE;
            state         <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          tgt_q  <= target_in;
          act_q  <= actual_in;
          mode_q <= angle_mode;
          ch     <= '0;
          state  <= ST_MAP;
        end
        ST_MAP: begin
          m_q   <= m_next;
          state <= ST_SCALE;
        end
        ST_SCALE: begin
          rate_q <= ss_rate;
          sat_q  <= ss_sat;
          err_q  <= sat_to_rate(m_q);
          state  <= ST_LIMIT;
        end
        ST_LIMIT: begin
          rate_sh <= rate_nx;
          err_sh  <= err_nx;
          sat_sh  <= sat_nx;
          if (ch == LAST_CH) begin
            rate_out        <= rate_nx;
            angle_error     <= err_nx;
            sat_flags       <= sat_nx;
            complete_signal <= TRUE;
            active_signal   <= FALSE;
            state           <= ST_COMPLETE;
          end else begin
            ch    <= ch + 1'b1;
            state <= ST_MAP;
          end
        end
        ST_COMPLETE: begin
          complete_signal <= FALSE;
          state           <= ST_IDLE;
        end
        default: begin
          active_signal   <= FALSE;
          complete_signal <= FALSE;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_axis_angle_controller.sv
// Self-checking bench: directed vector table, randomized passes against an
// arithmetic reference model, timing/reset sequences and a 6-axis build.
module tb_multi_axis_angle_controller;

  localparam int KM [4]  = '{1, 48, 32, 36};
  localparam int KS [4]  = '{0, 4, 4, 4};
  localparam int LIM [4] = '{4000, 1600, 1600, 1600};
  localparam logic [3:0] UNI = 4'b0001;
  localparam logic [3:0] INV = 4'b1000;

  logic        us_clk = 1'b0;
  logic        reset;
  logic        start_signal;
  logic [3:0]  angle_mode;
  logic [31:0] target_in;
  logic [63:0] actual_in;
  logic [63:0] rate_out;
  logic [63:0] angle_error;
  logic [3:0]  sat_flags;
  logic        active_signal;
  logic        complete_signal;

  logic        start6;
  logic [5:0]  mode6;
  logic [47:0] tgt6;
  logic [95:0] act6;
  logic [95:0] rate6;
  logic [95:0] err6;
  logic [5:0]  sat6;
  logic        active6;
  logic        complete6;

  int checks = 0;
  int errors = 0;

  always #5 us_clk = ~us_clk;

  multi_axis_angle_controller dut (
    .us_clk          (us_clk),
    .reset           (reset),
    .start_signal    (start_signal),
    .angle_mode      (angle_mode),
    .target_in       (target_in),
    .actual_in       (actual_in),
    .rate_out        (rate_out),
    .angle_error     (angle_error),
    .sat_flags       (sat_flags),
    .active_signal   (active_signal),
    .complete_signal (complete_signal)
  );

  multi_axis_angle_controller #(
    .N_AXES        (6),
    .K_MULT_VEC    ({8'd36, 8'd36, 8'd32, 8'd32, 8'd48, 8'd1}),
    .K_SHIFT_VEC   ({4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd0}),
    .LIMIT_VEC     ({16'd1600, 16'd1600, 16'd1600, 16'd1600, 16'd1600, 16'd4000}),
    .UNIPOLAR_MASK (6'b000001),
    .INVERT_MASK   (6'b001000)
  ) dut6 (
    .us_clk          (us_clk),
    .reset           (reset),
    .start_signal    (start6),
    .angle_mode      (mode6),
    .target_in       (tgt6),
    .actual_in       (act6),
    .rate_out        (rate6),
    .angle_error     (err6),
    .sat_flags       (sat6),
    .active_signal   (active6),
    .complete_signal (complete6)
  );

  typedef struct packed {
    logic [3:0][7:0]  tgt;
    logic [3:0][15:0] act;
    logic [3:0]       mode;
    logic [3:0][15:0] rate;
    logic [3:0][15:0] err;
    logic [3:0]       sat;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] t, input logic [63:0] a, input logic [3:0] m);
    @(negedge us_clk);
    target_in  = t;
    actual_in  = a;
    angle_mode = m;
  endtask

  // Pulse start for one cycle, scramble inputs once the snapshot is taken,
  // and report the cycle (relative to the start cycle) of complete.
  task automatic runPass(output int lat, output int act_bad);
    lat     = -1;
    act_bad = 0;
    @(negedge us_clk);
    start_signal = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge us_clk);
      if (n == 1) start_signal = 1'b0;
      if (n == 2) begin
        target_in  = $urandom;
        actual_in  = {$urandom, $urandom};
        angle_mode = 4'($urandom);
      end
      if (active_signal !== (complete_signal ? 1'b0 : 1'b1)) act_bad++;
      if (complete_signal === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // Reference: spec rules in plain integer arithmetic (floor division for >>>).
  task automatic refModel(input logic [31:0] tb, input logic [63:0] ab, input logic [3:0] md,
                          output logic [63:0] rb, output logic [63:0] eb, output logic [3:0] sb);
    int t, a, m, p, d, s, lo;
    rb = '0;
    eb = '0;
    sb = '0;
    for (int c = 0; c < 4; c++) begin
      t = 32'(tb[c*8 +: 8]);
      a = 32'($signed(ab[c*16 +: 16]));
      if (UNI[c]) m = t * 16;
      else begin
        m = t * 4 - 500;
        if (md[c]) m = INV[c] ? (m + a) : (m - a);
      end
      p = m * KM[c];
      d = 1 << KS[c];
      s = p / d;
      if ((p % d != 0) && (p < 0)) s = s - 1;
      lo = UNI[c] ? 0 : -LIM[c];
      if (s > LIM[c]) begin
        s = LIM[c];
        sb[c] = 1'b1;
      end else if (s < lo) begin
        s = lo;
        sb[c] = 1'b1;
      end
      rb[c*16 +: 16] = 16'(s);
      eb[c*16 +: 16] = 16'((m > 32767) ? 32767 : ((m < -32768) ? -32768 : m));
    end
  endtask

  initial begin
    int lat, act_bad, c1, c2, ncomp, saw;
    logic [31:0] tr;
    logic [63:0] ar, er_rate, er_err;
    logic [3:0]  mr, er_sat;
    logic        act15, act16;

    reset = 1'b1;
    start_signal = 1'b0;
    angle_mode = '0;
    target_in = '0;
    actual_in = '0;
    start6 = 1'b0;
    mode6 = '0;
    tgt6 = '0;
    act6 = '0;
    repeat (3) @(negedge us_clk);
    checkOutput("reset_rate", 128'(rate_out), 128'd0);
    checkOutput("reset_error", 128'(angle_error), 128'd0);
    checkOutput("reset_sat", 128'(sat_flags), 128'd0);
    checkOutput("reset_active", 128'(active_signal), 128'd0);
    checkOutput("reset_complete", 128'(complete_signal), 128'd0);
    reset = 1'b0;

    // Fields listed ch3..ch0.
    vecs[0].tgt = {8'd125, 8'd150, 8'd125, 8'd0};
    vecs[0].act = {16'sd32, 16'sd16, 16'sd0, 16'sd0};
    vecs[0].mode = 4'b1100;
    vecs[0].rate = {16'sd72, 16'sd168, 16'sd0, 16'sd0};
    vecs[0].err = {16'sd32, 16'sd84, 16'sd0, 16'sd0};
    vecs[0].sat = 4'b0000;

    vecs[1].tgt = {8'd125, 8'd150, 8'd125, 8'd200};
    vecs[1].act = {16'sd32, 16'sd16, 16'sd0, 16'sd0};
    vecs[1].mode = 4'b0000;
    vecs[1].rate = {16'sd0, 16'sd200, 16'sd0, 16'sd3200};
    vecs[1].err = {16'sd0, 16'sd100, 16'sd0, 16'sd3200};
    vecs[1].sat = 4'b0000;

    vecs[2].tgt = {8'd255, 8'd250, 8'd0, 8'd255};
    vecs[2].act = {16'sd0, -16'sd1000, 16'sd0, 16'sd0};
    vecs[2].mode = 4'b0100;
    vecs[2].rate = {16'sd1170, 16'sd1600, -16'sd1500, 16'sd4000};
    vecs[2].err = {16'sd520, 16'sd1500, -16'sd500, 16'sd4080};
    vecs[2].sat = 4'b0101;

    vecs[3].tgt = {8'd0, 8'd200, 8'd0, 8'd250};
    vecs[3].act = {-16'sd200, -16'sd500, 16'sd1000, 16'sd0};
    vecs[3].mode = 4'b1110;
    vecs[3].rate = {-16'sd1575, 16'sd1600, -16'sd1600, 16'sd4000};
    vecs[3].err = {-16'sd700, 16'sd800, -16'sd1500, 16'sd4000};
    vecs[3].sat = 4'b0010;

    vecs[4].tgt = {8'd255, 8'd0, 8'd0, 8'd1};
    vecs[4].act = {16'sd32767, -16'sd32768, 16'sd32767, 16'sd0};
    vecs[4].mode = 4'b1110;
    vecs[4].rate = {16'sd1600, 16'sd1600, -16'sd1600, 16'sd16};
    vecs[4].err = {16'sd32767, 16'sd32268, -16'sd32768, 16'sd16};
    vecs[4].sat = 4'b1110;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].tgt, vecs[i].act, vecs[i].mode);
      runPass(lat, act_bad);
      checkOutput($sformatf("vec%0d_latency", i), 128'(lat), 128'd14);
      checkOutput($sformatf("vec%0d_active", i), 128'(act_bad), 128'd0);
      checkOutput($sformatf("vec%0d_rate", i), 128'(rate_out), 128'(vecs[i].rate));
      checkOutput($sformatf("vec%0d_error", i), 128'(angle_error), 128'(vecs[i].err));
      checkOutput($sformatf("vec%0d_sat", i), 128'(sat_flags), 128'(vecs[i].sat));
    end

    for (int i = 0; i < 40; i++) begin
      tr = $urandom;
      ar = {$urandom, $urandom};
      mr = 4'($urandom);
      refModel(tr, ar, mr, er_rate, er_err, er_sat);
      applyStimulus(tr, ar, mr);
      runPass(lat, act_bad);
      checkOutput($sformatf("rand%0d_latency", i), 128'(lat), 128'd14);
      checkOutput($sformatf("rand%0d_rate", i), 128'(rate_out), 128'(er_rate));
      checkOutput($sformatf("rand%0d_error", i), 128'(angle_error), 128'(er_err));
      checkOutput($sformatf("rand%0d_sat", i), 128'(sat_flags), 128'(er_sat));
    end

    // Second start during the pass, then exactly in the COMPLETE cycle.
    for (int k = 0; k < 2; k++) begin
      c1 = -1;
      c2 = -1;
      ncomp = 0;
      act15 = 1'b1;
      act16 = 1'b0;
      @(negedge us_clk);
      start_signal = 1'b1;
      for (int n = 1; n <= 40; n++) begin
        @(negedge us_clk);
        start_signal = (n == ((k == 0) ? 5 : 14));
        if (complete_signal === 1'b1) begin
          ncomp++;
          if (c1 < 0) c1 = n;
          else c2 = n;
        end
        if (n == 15) act15 = active_signal;
        if (n == 16) act16 = active_signal;
      end
      start_signal = 1'b0;
      checkOutput($sformatf("b2b%0d_first", k), 128'(c1), 128'd14);
      checkOutput($sformatf("b2b%0d_second", k), 128'(c2), 128'd29);
      checkOutput($sformatf("b2b%0d_count", k), 128'(ncomp), 128'd2);
      checkOutput($sformatf("b2b%0d_idle_gap", k), 128'({act15, act16}), 128'b01);
    end

    // Asynchronous reset in the middle of a pass.
    applyStimulus(vecs[2].tgt, vecs[2].act, vecs[2].mode);
    runPass(lat, act_bad);
    checkOutput("prereset_rate", 128'(rate_out), 128'(vecs[2].rate));
    @(negedge us_clk);
    start_signal = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge us_clk);
      if (n == 1) start_signal = 1'b0;
    end
    reset = 1'b1;
    #1;
    checkOutput("midreset_rate", 128'(rate_out), 128'd0);
    checkOutput("midreset_error", 128'(angle_error), 128'd0);
    checkOutput("midreset_sat", 128'(sat_flags), 128'd0);
    checkOutput("midreset_active", 128'(active_signal), 128'd0);
    saw = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge us_clk);
      if (n == 2) reset = 1'b0;
      if (complete_signal !== 1'b0) saw++;
    end
    checkOutput("midreset_no_complete", 128'(saw), 128'd0);
    checkOutput("postreset_rate_held", 128'(rate_out), 128'd0);
    applyStimulus(vecs[0].tgt, vecs[0].act, vecs[0].mode);
    runPass(lat, act_bad);
    checkOutput("postreset_latency", 128'(lat), 128'd14);
    checkOutput("postreset_rate", 128'(rate_out), 128'(vecs[0].rate));
    checkOutput("postreset_error", 128'(angle_error), 128'(vecs[0].err));

    // Six-axis build in rate mode: bipolar channels map to zero.
    @(negedge us_clk);
    tgt6 = {6{8'd125}};
    act6 = {$urandom, $urandom, $urandom};
    mode6 = '0;
    @(negedge us_clk);
    start6 = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge us_clk);
      if (n == 1) start6 = 1'b0;
      if (complete6 === 1'b1) begin
        lat = n;
        break;
      end
    end
    checkOutput("n6_latency", 128'(lat), 128'd20);
    checkOutput("n6_rate", 128'(rate6), {32'd0, 80'd0, 16'd2000});
    checkOutput("n6_error", 128'(err6), {32'd0, 80'd0, 16'd2000});
    checkOutput("n6_sat", 128'(sat6), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
